// File: rtl/stream_demux2x32_pkg.sv
// Shared definitions for the 2-way stream demultiplexer: per-port FIFO state
// encoding and queue depth.
package stream_demux2x32_pkg;

  localparam int unsigned FifoDepth = 2;
  localparam int unsigned CountW    = $clog2(FifoDepth + 1);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/stream_demux2x32_if.sv
// Handshake bundle for stream_demux2x32: one input stream, two output streams.
interface stream_demux2x32_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [1:0]       out0_count;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [1:0]       out1_count;

  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_count, out1_valid, out1_data, out1_count
  );

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_count, out1_valid, out1_data, out1_count
  );

endinterface

// File: rtl/demux_fifo2.sv
// Two-entry registered FIFO; head word is always in head_q so the output has no
// combinational path from the write data.
module demux_fifo2
  import stream_demux2x32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ready,
  output logic              valid,
  output logic [WIDTH-1:0]  data,
  output logic [CountW-1:0] count,
  output logic              full
);

  fifo_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pop     = (state_q != StEmpty) && ready;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          state_d = StOne;
          head_d  = wdata;
        end
      end
      StOne: begin
        if (push && pop) begin
          head_d = wdata;
        end else if (push) begin
          state_d = StFull;
          tail_d  = wdata;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      // Push is gated off upstream while full.
      StFull: begin
        if (pop) begin
          state_d = StOne;
          head_d  = tail_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  assign valid = (state_q != StEmpty);
  assign data  = head_q;
  assign count = state_q;
  assign full  = (state_q == StFull);

endmodule

// File: rtl/stream_demux2x32.sv
// Routes each accepted input word to one of two independent 2-entry port FIFOs
// chosen by in_sel.
module stream_demux2x32
  import stream_demux2x32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  stream_demux2x32_if.slave bus
);

  logic full0, full1;
  logic push0, push1;

  // Ready depends only on the selected FIFO, never on in_valid.
  assign bus.in_ready = bus.in_sel ? !full1 : !full0;
  assign push0        = bus.in_valid && !bus.in_sel && !full0;
  assign push1        = bus.in_valid &&  bus.in_sel && !full1;

  demux_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo0 (
    .clk  (clk),
    .rst  (rst),
    .push (push0),
    .wdata(bus.in_data),
    .ready(bus.out0_ready),
    .valid(bus.out0_valid),
    .data (bus.out0_data),
    .count(bus.out0_count),
    .full (full0)
  );

  demux_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo1 (
    .clk  (clk),
    .rst  (rst),
    .push (push1),
    .wdata(bus.in_data),
    .ready(bus.out1_ready),
    .valid(bus.out1_valid),
    .data (bus.out1_data),
    .count(bus.out1_count),
    .full (full1)
  );

endmodule

// File: tb/tb_stream_demux2x32.sv
// Bench for stream_demux2x32: directed scenarios plus random traffic, checked by
// a queue-based reference model sampled on the falling clock edge.
module tb_stream_demux2x32;

  logic clk;
  logic rst;

  stream_demux2x32_if #(.WIDTH(32)) bus ();

  stream_demux2x32 #(
    .WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int unsigned pops0    = 0;
  int unsigned pushes   = 0;
  int unsigned pops_all = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endfunction

  // Reference model: each port is an unbounded-semantics queue capped at two words.
  always @(negedge clk) begin
    logic exp_rdy, acc, pop0, pop1;
    if (rst) begin
      check("rst_out0_valid", 64'(bus.out0_valid), 64'(0));
      check("rst_out1_valid", 64'(bus.out1_valid), 64'(0));
      check("rst_out0_count", 64'(bus.out0_count), 64'(0));
      check("rst_out1_count", 64'(bus.out1_count), 64'(0));
      check("rst_in_ready", 64'(bus.in_ready), 64'(1));
      check("rst_out0_data", 64'(bus.out0_data), 64'(0));
      check("rst_out1_data", 64'(bus.out1_data), 64'(0));
      q0.delete();
      q1.delete();
    end else begin
      check("out0_valid", 64'(bus.out0_valid), 64'(q0.size() > 0));
      check("out1_valid", 64'(bus.out1_valid), 64'(q1.size() > 0));
      check("out0_count", 64'(bus.out0_count), 64'(q0.size()));
      check("out1_count", 64'(bus.out1_count), 64'(q1.size()));
      if (q0.size() > 0) check("out0_data", 64'(bus.out0_data), 64'(q0[0]));
      if (q1.size() > 0) check("out1_data", 64'(bus.out1_data), 64'(q1[0]));
      exp_rdy = bus.in_sel ? (q1.size() < 2) : (q0.size() < 2);
      check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      acc  = bus.in_valid && exp_rdy;
      pop0 = (q0.size() > 0) && bus.out0_ready;
      pop1 = (q1.size() > 0) && bus.out1_ready;
      if (pop0) begin
        void'(q0.pop_front());
        pops0++;
        pops_all++;
      end
      if (pop1) begin
        void'(q1.pop_front());
        pops_all++;
      end
      if (acc) begin
        if (bus.in_sel) q1.push_back(bus.in_data);
        else q0.push_back(bus.in_data);
        pushes++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic s, logic [31:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int unsigned p0_start;
    int unsigned max_cnt;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Routing
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    drive(1'b1, 1'b0, 32'hA5A5_A5A5);
    cyc();
    drive(1'b1, 1'b1, 32'h5A5A_5A5A);
    at_neg();
    check("route_p0_data", 64'(bus.out0_data), 64'h0000_0000_A5A5_A5A5);
    check("route_p1_idle", 64'(bus.out1_valid), 64'(0));
    cyc();
    drive(1'b0, 1'b0, '0);
    at_neg();
    check("route_p1_data", 64'(bus.out1_data), 64'h0000_0000_5A5A_5A5A);
    check("route_p0_idle", 64'(bus.out0_valid), 64'(0));
    cyc();

    // Backpressure on port 1
    bus.out1_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h1111_0001);
    cyc();
    drive(1'b1, 1'b1, 32'h1111_0002);
    cyc();
    drive(1'b1, 1'b1, 32'h1111_0003);
    at_neg();
    check("bp_in_ready", 64'(bus.in_ready), 64'(0));
    check("bp_count1", 64'(bus.out1_count), 64'(2));
    cyc();
    drive(1'b1, 1'b0, 32'h2222_0001);
    at_neg();
    check("bp_p0_ready", 64'(bus.in_ready), 64'(1));
    cyc();
    drive(1'b0, 1'b0, '0);
    bus.out1_ready = 1'b1;
    repeat (3) cyc();

    // Port 0 full with simultaneous pop
    bus.out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h3333_0001);
    cyc();
    drive(1'b1, 1'b0, 32'h3333_0002);
    cyc();
    bus.out0_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h3333_0003);
    at_neg();
    check("fp_in_ready", 64'(bus.in_ready), 64'(0));
    check("fp_count_full", 64'(bus.out0_count), 64'(2));
    cyc();
    at_neg();
    check("fp_count_one", 64'(bus.out0_count), 64'(1));
    check("fp_ready_next", 64'(bus.in_ready), 64'(1));
    cyc();
    drive(1'b0, 1'b0, '0);
    repeat (3) cyc();

    // Throughput
    max_cnt  = 0;
    p0_start = pops0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b0, 32'(i));
      at_neg();
      if (32'(bus.out0_count) > max_cnt) max_cnt = 32'(bus.out0_count);
      cyc();
    end
    drive(1'b0, 1'b0, '0);
    at_neg();
    check("tput_pops", 64'(pops0 - p0_start), 64'(100));
    check("tput_max_count", 64'(max_cnt), 64'(1));
    cyc();

    // Reset mid-stream with both FIFOs full
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h4444_0001);
    cyc();
    drive(1'b1, 1'b0, 32'h4444_0002);
    cyc();
    drive(1'b1, 1'b1, 32'h4444_0003);
    cyc();
    drive(1'b1, 1'b1, 32'h4444_0004);
    cyc();
    drive(1'b0, 1'b0, '0);
    at_neg();
    check("pre_rst_count0", 64'(bus.out0_count), 64'(2));
    check("pre_rst_count1", 64'(bus.out1_count), 64'(2));
    #1;
    rst = 1'b1;
    #1;
    check("async_out0_valid", 64'(bus.out0_valid), 64'(0));
    check("async_out1_valid", 64'(bus.out1_valid), 64'(0));
    check("async_count0", 64'(bus.out0_count), 64'(0));
    check("async_count1", 64'(bus.out1_count), 64'(0));
    check("async_in_ready", 64'(bus.in_ready), 64'(1));
    drive(1'b1, 1'b0, 32'h5555_0001);
    repeat (2) cyc();
    drive(1'b0, 1'b0, '0);
    rst = 1'b0;
    cyc();

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      bus.out0_ready = 1'($urandom_range(0, 1));
      bus.out1_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    drive(1'b0, 1'b0, '0);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    repeat (4) cyc();
    at_neg();
    check("drain_q0_empty", 64'(q0.size()), 64'(0));
    check("drain_q1_empty", 64'(q1.size()), 64'(0));
    check("drain_out0_valid", 64'(bus.out0_valid), 64'(0));
    check("drain_out1_valid", 64'(bus.out1_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
